// File: rtl/fetch_queue.sv
// Instruction fetcher with one outstanding request feeding an in-order queue of DEPTH entries.
// Optional macro FETCH_QUEUE_BYPASS_EN: a response arriving at an empty queue is presented the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_adr,
    input  logic        mem_grant,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus_4,
    output logic        instr_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   pend_pc;
    logic          outstanding;
    logic          discard;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [CW:0] occ;
    logic        empty;
    logic        accept;
    logic        resp;
    logic        bypass;
    logic        push;
    logic        pop;

    assign empty     = (count == '0);
    assign occ       = {1'b0, count} + {{CW{1'b0}}, outstanding};
    // Gated by reset so no request is presented while the block is held in reset.
    assign fetch_req = reset & ~redirect & (occ < DEPTH_W) & ~outstanding;
    assign fetch_adr = fetch_pc;
    assign accept    = fetch_req & mem_grant;
    assign resp      = mem_valid & outstanding & ~discard;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & resp & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = ~empty | bypass;
    assign pop         = ~empty & deq & ~redirect;
    // A bypassed word consumed in the same cycle never enters storage.
    assign push        = resp & ~redirect & ~(bypass & deq);

    always_comb begin
        instr           = '0;
        instr_pc        = '0;
        instr_pc_plus_4 = '0;
        if (!empty) begin
            instr           = word_q[head];
            instr_pc        = pc_q[head];
            instr_pc_plus_4 = pc_q[head] + 32'd4;
        end else if (bypass) begin
            instr           = mem_rdata;
            instr_pc        = pend_pc;
            instr_pc_plus_4 = pend_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            pend_pc     <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            if (redirect)    fetch_pc <= redirect_pc;
            else if (accept) fetch_pc <= fetch_pc + 32'd4;

            if (accept) pend_pc <= fetch_pc;

            if (accept)         outstanding <= 1'b1;
            else if (mem_valid) outstanding <= 1'b0;

            // A response landing in the redirect cycle is dropped there, so no discard is needed.
            if (mem_valid & outstanding)     discard <= 1'b0;
            else if (redirect & outstanding) discard <= 1'b1;

            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop)  head <= head + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[tail] <= mem_rdata;
            pc_q[tail]   <= pend_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) assert (!(push && count == FULL));
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected PCs, a monitor checks every consumed entry.
module tb_fetch_queue;
    logic clk;
    logic reset;
    logic fetch_req, mem_grant, mem_valid, redirect, deq, instr_valid;
    logic [31:0] fetch_adr, mem_rdata, redirect_pc, instr, instr_pc, instr_pc_plus_4;

    logic w_fetch_req, w_mem_valid, w_instr_valid;
    logic [31:0] w_fetch_adr, w_mem_rdata, w_instr, w_instr_pc, w_instr_pc_plus_4;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int w_n = 0;
    int w_p = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_fetch;
    logic [31:0] w_exp [3];

    logic        acc;
    logic        pend_v;
    logic [31:0] pend_adr;
    int          pend_cnt;
    int          lat;

    fetch_queue u_dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_adr(fetch_adr),
        .mem_grant(mem_grant), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .instr(instr), .instr_pc(instr_pc), .instr_pc_plus_4(instr_pc_plus_4),
        .instr_valid(instr_valid)
    );

    fetch_queue #(.RESET_PC(32'hFFFFFFF8)) u_wrap (
        .clk(clk), .reset(reset), .fetch_req(w_fetch_req), .fetch_adr(w_fetch_adr),
        .mem_grant(1'b1), .mem_valid(w_mem_valid), .mem_rdata(w_mem_rdata),
        .redirect(1'b0), .redirect_pc(32'h0), .deq(1'b1),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_pc_plus_4(w_instr_pc_plus_4),
        .instr_valid(w_instr_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h00500093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no acceptance expected one within 10 cycles", name);
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Memory model: answers an accepted request after lat cycles.
    task automatic sample();
        @(negedge clk);
        acc = fetch_req & mem_grant;
        if (acc) begin
            chk("fetch_adr", fetch_adr, exp_fetch);
            exp_fetch += 32'd4;
            pend_v   = 1'b1;
            pend_adr = fetch_adr;
            pend_cnt = lat;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_rdata = 32'h0;
        if (pend_v) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = word(pend_adr);
                pend_v    = 1'b0;
            end
        end
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    // Scoreboard monitor: redirect and reset flush what was expected.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (!reset || redirect) begin
            exp_q.delete();
        end else if (instr_valid && deq) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop: got entry pc %h expected none", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e);
                chk("instr", instr, word(e));
                chk("instr_pc_plus_4", instr_pc_plus_4, e + 32'd4);
                pops++;
            end
        end
    end

    // Wrap-around instance: own single-cycle responder, first three fetches and pops checked.
    initial begin : wrap_side
        logic        a;
        logic [31:0] adr;
        w_exp[0] = 32'hFFFFFFF8;
        w_exp[1] = 32'hFFFFFFFC;
        w_exp[2] = 32'h0;
        w_mem_valid = 1'b0;
        w_mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            a   = reset && w_fetch_req;
            adr = w_fetch_adr;
            if (a && w_n < 3) begin
                chk("wrap fetch_adr", w_fetch_adr, w_exp[w_n]);
                w_n++;
            end
            if (reset && w_instr_valid && w_p < 3) begin
                chk("wrap instr_pc", w_instr_pc, w_exp[w_p]);
                chk("wrap instr", w_instr, word(w_exp[w_p]));
                chk("wrap pc_plus_4", w_instr_pc_plus_4, w_exp[w_p] + 32'd4);
                w_p++;
            end
            @(posedge clk);
            #1;
            w_mem_valid = a;
            w_mem_rdata = a ? word(adr) : 32'h0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1);
    end

    initial begin : stim
        int  p0;
        int  req_seen;
        logic got;
        reset = 1'b0; mem_grant = 1'b1; mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        redirect = 1'b0; redirect_pc = 32'h0; deq = 1'b1;
        lat = 1; pend_v = 1'b0; pend_cnt = 0; pend_adr = 32'h0; exp_fetch = 32'h0; acc = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst fetch_req", 32'(fetch_req), 32'd0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst instr", instr, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst pc_plus_4", instr_pc_plus_4, 32'h0);
        chk("rst fetch_adr", fetch_adr, 32'h0);

        // Release with a stray mem_valid in the first cycle
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_exp(32'h0, 32);
        sample();
        chk("c0 fetch_req", 32'(fetch_req), 32'd1);
        chk("c0 instr_valid", 32'(instr_valid), 32'd0);
        advance();
        sample();
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("c1 bypass valid", 32'(instr_valid), 32'd1);
        chk("c1 bypass instr", instr, 32'h00500093);
`else
        chk("c1 instr_valid", 32'(instr_valid), 32'd0);
`endif
        advance();
        sample();
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("c2 instr_valid", 32'(instr_valid), 32'd0);
`else
        chk("c2 instr_valid", 32'(instr_valid), 32'd1);
        chk("c2 instr", instr, 32'h00500093);
`endif
        advance();
        repeat (9) tick();
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("stream pops", 32'(pops), 32'd6);
`else
        chk("stream pops", 32'(pops), 32'd5);
`endif

        // Stall: queue fills to DEPTH and fetching stops
        deq = 1'b0;
        repeat (11) tick();
        sample();
        chk("full fetch_req", 32'(fetch_req), 32'd0);
        chk("full instr_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("full head pc", instr_pc, 32'h18);
`else
        chk("full head pc", instr_pc, 32'h14);
`endif
        advance();
        deq = 1'b1;
        repeat (4) begin
            sample();
            chk("drain valid", 32'(instr_valid), 32'd1);
            advance();
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("drain pops", 32'(pops), 32'd10);
`else
        chk("drain pops", 32'(pops), 32'd9);
`endif

        // Port busy: fetch PC and request held
        repeat (3) tick();
        mem_grant = 1'b0;
        req_seen  = 0;
        repeat (3) begin
            sample();
            chk("grant-low fetch_adr", fetch_adr, exp_fetch);
            if (fetch_req) req_seen++;
            advance();
        end
        chk("grant-low req held", 32'(req_seen >= 1), 32'd1);
        mem_grant = 1'b1;
        repeat (4) tick();

        // Redirect while a slow response is outstanding
        lat = 3;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = acc;
        end
        if (!got) timeout_fail("redirect setup");
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        sample();
        chk("redir fetch_req", 32'(fetch_req), 32'd0);
        advance();
        redirect  = 1'b0;
        lat       = 1;
        exp_fetch = 32'h100;
        push_exp(32'h100, 16);
        sample();
        chk("post-redir empty", 32'(instr_valid), 32'd0);
        chk("post-redir no req", 32'(fetch_req), 32'd0);
        advance();
        sample();
        chk("stale resp empty", 32'(instr_valid), 32'd0);
        chk("stale resp no req", 32'(fetch_req), 32'd0);
        advance();
        sample();
        chk("stale dropped", 32'(instr_valid), 32'd0);
        chk("redir refetch req", 32'(fetch_req), 32'd1);
        chk("redir refetch adr", fetch_adr, 32'h100);
        advance();
        p0 = pops;
        repeat (6) tick();
        chk("redir pops", 32'(pops - p0), 32'd3);

        // Reset in the middle of a request
        lat = 3;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = acc;
        end
        if (!got) timeout_fail("mid-reset setup");
        reset = 1'b0;
        sample();
        chk("mid-rst fetch_req", 32'(fetch_req), 32'd0);
        chk("mid-rst instr_valid", 32'(instr_valid), 32'd0);
        chk("mid-rst fetch_adr", fetch_adr, 32'h0);
        advance();
        sample();
        advance();
        reset     = 1'b1;
        lat       = 1;
        exp_fetch = 32'h0;
        push_exp(32'h0, 16);
        sample();
        chk("rel fetch_req", 32'(fetch_req), 32'd1);
        chk("rel stale ignored", 32'(instr_valid), 32'd0);
        advance();
        sample();
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("rel bypass instr", instr, 32'h00500093);
`else
        chk("rel latency", 32'(instr_valid), 32'd0);
`endif
        advance();
        p0 = pops;
        repeat (6) tick();
        chk("rel pops", 32'(pops - p0), 32'd3);

        chk("wrap fetch count", 32'(w_n), 32'd3);
        chk("wrap pop count", 32'(w_p), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
